wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
- Wishbone B4 responder: single-port, byte-enabled on-chip SRAM that terminates one slave port (s0..s5) of the 1xN interconnects.
- Supports classic cycles and registered-feedback bursts:
  - CTI constant-address and incrementing.
  - BTE linear and wrap-4/8/16.
- Out-of-window accesses terminate with ERR.

Parameters:
- WB_ADDR_WIDTH, 32, byte-address width.
- WB_DATA_WIDTH, 32, data width; must be a multiple of 8.
- BASE_ADDR, 'h0, byte address of word 0; must be word-aligned.
- DEPTH, 1024, number of words.
- INIT_FILE, "", optional $readmemh image; empty means the array is uninitialised.

Ports:
Clock and reset are `clk` and `rst`; `rst` is synchronous, active-high. All other ports form one `wb_if.slave` port named `s`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s.ADR  in  WB_ADDR_WIDTH  byte address
- s.CTI  in  3  cycle type
- s.BTE  in  2  burst type
- s.DAT_W  in  WB_DATA_WIDTH  write data
- s.SEL  in  WB_DATA_WIDTH/8  byte enables
- s.CYC  in  1  cycle
- s.STB  in  1  strobe
- s.WE  in  1  write enable
- s.DAT_R  out  WB_DATA_WIDTH  read data
- s.ACK  out  1  acknowledge
- s.ERR  out  1  error

Behaviour:
- Reset: state=IDLE; ack_q=0, err_q=0, so ACK=0 and ERR=0; DAT_R=0. Memory contents are not reset.
- Definitions:
  - req = CYC & STB.
  - idx = (ADR-BASE_ADDR) >> log2(WB_DATA_WIDTH/8).
  - in_range = (ADR >= BASE_ADDR) && (idx < DEPTH).
  - Low ADR bits are ignored.
- Output gating: ACK = ack_q & req and ERR = err_q & req. A master dropping STB/CYC never sees a stale termination.
- State IDLE:
  - On req & !in_range: set err_q for one cycle, go to ERRW.
  - On req & in_range & CTI in {000, 111}, or unsupported CTI/BTE combos: go to CLASSIC. Memory reads idx.
  - On req & in_range & CTI in {001, 010}: go to BURST. Memory reads idx; rd_idx = next(idx).
- CLASSIC: ack_q=1 for exactly one cycle (latency 1, ACK on 2nd cycle of the strobe); then IDLE, with ACK low for at least one cycle.
- BURST: ack_q=1 every cycle while req.
  - Each acked beat prefetches rd_idx; rd_idx = next(rd_idx). Zero wait states after the first beat.
  - Beat with CTI=111 is the last: ACK it, then IDLE.
  - req low in BURST: ack_q clears, go to IDLE. A resumed STB restarts as a new access (re-latency 1).
- ERRW: err_q for one cycle, then IDLE. No memory write.
- Writes: performed in the cycle ACK=1 && WE, at the current ADR-derived idx. Byte lane i is written iff SEL[i].
- Reads: DAT_R holds registered memory output, valid while ACK=1. It holds its value otherwise.
- next(x):
  - CTI=001: x.
  - CTI=010 with BTE=00: x+1, linear.
  - BTE=01/10/11: increment only the low 2/3/4 bits, wrapping; upper bits unchanged.
  - Linear increment past DEPTH-1 is not checked mid-burst. The master's ADR for that beat is out of range, so the slave terminates with ERR on that beat and returns to IDLE.
- Read-after-write in the same burst at the same idx (constant burst): the read returns the new data, via write-to-read bypass on the prefetch port.
- CYC deassert in any state: next cycle IDLE. Any pending write that was not acked is dropped.
- rst mid-burst: IDLE next cycle, ACK/ERR=0, no write in the reset cycle.

Decomposition:
- wb_pkg (shared):
  - CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16.
  - function wb_next_idx(idx, cti, bte), reusable by the interconnect tests and masters.
- Sub-module wb_sram_be holds the byte-enabled single-port RAM:
  - Synchronous read, write-first.
  - INIT_FILE hook.
- wb_sram_slave holds the FSM, range check and address generator.

Test Plan:
1. Classic path, BASE_ADDR='h1000, DEPTH=16:
   - Classic write ADR='h1004, DAT_W='hDEADBEEF, SEL=4'b1111 -> ACK on cycle 2, one cycle.
   - Classic read of 'h1004 -> DAT_R='hDEADBEEF with ACK.
2. Byte-lane write: SEL=4'b0010, DAT_W='h0000AA00 to 'h1004, then read -> 'hDEADAAEF.
3. Incrementing wrap-4 burst: CTI=010, BTE=01, start 'h1008, 4 beats (last CTI=111) after memory preload idx n = n.
   - Beats read idx 2,3,0,1.
   - ACK high 4 consecutive cycles, then low.
4. Out-of-range:
   - ADR='h0FFC -> ERR one cycle, ACK=0, memory unchanged.
   - ADR='h1040 -> same.
5. Aborts:
   - Linear read burst from idx 0 with CYC dropped after beat 2 -> ACK low that cycle, IDLE next.
   - A following classic read succeeds.
6. Reset: assert rst during beat 3 of an 8-beat write burst -> ACK=0 next cycle; words 0-1 written, word 2 untouched.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings and the burst address-sequencing helper used by
// slaves, masters and interconnect tests alike.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST,
        ST_ERRW
    } wb_slv_state_e;

    // Word index of the beat following idx; wrap modes only touch the low bits.
    function automatic logic [31:0] wb_next_idx(input logic [31:0] idx,
                                                input logic [2:0]  cti,
                                                input logic [1:0]  bte);
        logic [31:0] n;
        n = idx;
        if (cti == CTI_INCR) begin
            case (bte)
                BTE_LINEAR: n = idx + 32'd1;
                BTE_WRAP4:  n = {idx[31:2], idx[1:0] + 2'd1};
                BTE_WRAP8:  n = {idx[31:3], idx[2:0] + 3'd1};
                default:    n = {idx[31:4], idx[3:0] + 4'd1};
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined-less bus bundle with registered-feedback burst tags.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   ADR;
    logic [2:0]      CTI;
    logic [1:0]      BTE;
    logic [DW-1:0]   DAT_W;
    logic [DW/8-1:0] SEL;
    logic            CYC;
    logic            STB;
    logic            WE;
    logic [DW-1:0]   DAT_R;
    logic            ACK;
    logic            ERR;

    modport master (output ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
                    input  DAT_R, ACK, ERR);
    modport slave  (input  ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
                    output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_sram_be.sv
// Single-port byte-enabled RAM, synchronous read, write-first: a write returns
// the merged word on dout, which gives read-after-write bypass for free.
module wb_sram_be #(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 1024,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   din_i,
  output logic [DW-1:0]   dout_o
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] merged;
  logic [DW-1:0] dout_q;

  always_comb begin
    merged = mem[addr_i];
    for (int i = 0; i < DW/8; i++) begin
      if (we_i && be_i[i]) merged[i*8 +: 8] = din_i[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++) begin
      if (en_i && we_i && be_i[i]) mem[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
    end
  end

  // Output register is the only reset state; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)       dout_q <= '0;
    else if (en_i) dout_q <= merged;
  end

  assign dout_o = dout_q;
endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 SRAM responder: window decode, classic/burst FSM and burst
// address prefetch in front of a byte-enabled single-port RAM.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int                        WB_ADDR_WIDTH = 32,
    parameter int                        WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0]  BASE_ADDR     = '0,
    parameter int                        DEPTH         = 1024,
    parameter string                     INIT_FILE     = ""
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  s
);
    localparam int SELW = WB_DATA_WIDTH / 8;
    localparam int LSB  = $clog2(SELW);
    localparam int RAW  = $clog2(DEPTH);

    wb_slv_state_e      state_q;
    logic               ack_q;
    logic               err_q;
    logic [31:0]        rd_idx_q;

    logic                     req;
    logic [WB_ADDR_WIDTH-1:0] off;
    logic [WB_ADDR_WIDTH-1:0] idx_full;
    logic [31:0]              cur_idx;
    logic                     in_range;
    logic                     rd_in_range;
    logic                     ack_fire;
    logic                     burst_cti;

    logic                     ram_en;
    logic                     ram_we;
    logic [RAW-1:0]           ram_addr;
    logic [WB_DATA_WIDTH-1:0] ram_dout;

    assign req         = s.CYC & s.STB;
    assign off         = s.ADR - BASE_ADDR;
    assign idx_full    = off >> LSB;
    assign cur_idx     = 32'(idx_full);
    assign in_range    = (s.ADR >= BASE_ADDR) && (idx_full < WB_ADDR_WIDTH'(DEPTH));
    assign rd_in_range = rd_idx_q < 32'(DEPTH);
    assign ack_fire    = ack_q & req;
    assign burst_cti   = (s.CTI == CTI_CONST) || (s.CTI == CTI_INCR);

    // Writes go to the ADR-derived index of the acked beat; otherwise the port
    // serves the prefetch so the next burst beat needs no wait state.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = rd_idx_q[RAW-1:0];
        case (state_q)
            ST_IDLE: begin
                if (req && in_range) begin
                    ram_en   = 1'b1;
                    ram_addr = cur_idx[RAW-1:0];
                end
            end
            ST_CLASSIC: begin
                if (ack_fire && s.WE && in_range) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cur_idx[RAW-1:0];
                end
            end
            ST_BURST: begin
                if (ack_fire && s.WE && in_range) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cur_idx[RAW-1:0];
                end else if (ack_fire && !s.WE && s.CTI != CTI_EOB && rd_in_range) begin
                    ram_en   = 1'b1;
                end
            end
            default: ;
        endcase
        ram_we = ram_we & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERRW;
                        end else if (burst_cti) begin
                            ack_q    <= 1'b1;
                            rd_idx_q <= wb_next_idx(cur_idx, s.CTI, s.BTE);
                            state_q  <= ST_BURST;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= ST_CLASSIC;
                        end
                    end
                end
                ST_BURST: begin
                    if (!ack_fire || s.CTI == CTI_EOB) begin
                        state_q <= ST_IDLE;
                    end else if (!rd_in_range) begin
                        // Linear run off the end: the master's next beat lands outside the window.
                        err_q   <= 1'b1;
                        state_q <= ST_ERRW;
                    end else begin
                        ack_q    <= 1'b1;
                        rd_idx_q <= wb_next_idx(rd_idx_q, s.CTI, s.BTE);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wb_sram_be #(
        .DW        (WB_DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (RAW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .be_i   (s.SEL),
        .addr_i (ram_addr),
        .din_i  (s.DAT_W),
        .dout_o (ram_dout)
    );

    assign s.DAT_R = ram_dout;
    assign s.ACK   = ack_q & req;
    assign s.ERR   = err_q & req;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: 16-word window at 0x1000, classic, burst,
// window-error, abort and reset sequences with hand-computed expectations.
module tb_wb_sram_slave;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_if #(.AW(32), .DW(32)) bus ();

    wb_sram_slave #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .BASE_ADDR     (32'h1000),
        .DEPTH         (16),
        .INIT_FILE     ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] w4_adr [4];
    logic [31:0] w4_exp [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        bus.ADR = '0; bus.CTI = CTI_CLASSIC; bus.BTE = BTE_LINEAR;
        bus.DAT_W = '0; bus.SEL = 4'hf;
    endtask

    task automatic beat(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we;
        bus.ADR = adr; bus.CTI = cti; bus.BTE = bte;
        bus.DAT_W = dat; bus.SEL = sel;
    endtask

    // One classic access: samples first-cycle ACK, then ACK/ERR/DAT_R on cycle 2.
    task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic a1, output logic a2,
                           output logic e2, output logic [31:0] rd);
        beat(adr, we, dat, sel, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk); a1 = bus.ACK;
        tick();
        @(negedge clk); a2 = bus.ACK; e2 = bus.ERR; rd = bus.DAT_R;
        tick();
        idle_bus();
        tick();
    endtask

    initial begin
        logic        a1, a2, e2;
        logic [31:0] rd;
        w4_adr = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        w4_exp = '{32'd2, 32'd3, 32'd0, 32'd1};

        rst = 1'b1;
        idle_bus();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(bus.ACK), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk("rst_datr", bus.DAT_R, 32'h0);
        tick();

        // classic write, holding STB a third cycle to see ACK drop
        beat(32'h1004, 1'b1, 32'hDEADBEEF, 4'hf, CTI_CLASSIC, BTE_LINEAR);
        @(negedge clk); chk("cw_c1_ack", 32'(bus.ACK), 32'd0);
        tick();
        @(negedge clk); chk("cw_c2_ack", 32'(bus.ACK), 32'd1);
        tick();
        @(negedge clk); chk("cw_c3_ack", 32'(bus.ACK), 32'd0);
        tick();
        idle_bus();
        tick();
        tick();

        classic(32'h1004, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("cr_c1_ack", 32'(a1), 32'd0);
        chk("cr_c2_ack", 32'(a2), 32'd1);
        chk("cr_data", rd, 32'hDEADBEEF);

        classic(32'h1004, 1'b1, 32'h0000AA00, 4'b0010, a1, a2, e2, rd);
        chk("bl_wr_ack", 32'(a2), 32'd1);
        classic(32'h1004, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("bl_data", rd, 32'hDEADAAEF);

        for (int n = 0; n < 16; n++) classic(32'h1000 + 32'(4 * n), 1'b1, 32'(n), 4'hf, a1, a2, e2, rd);

        // wrap-4 incrementing read burst from idx 2
        beat(w4_adr[0], 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_WRAP4);
        @(negedge clk); chk("w4_lat_ack", 32'(bus.ACK), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("w4_ack%0d", k), 32'(bus.ACK), 32'd1);
            chk($sformatf("w4_dat%0d", k), bus.DAT_R, w4_exp[k]);
            tick();
            if (k < 3) beat(w4_adr[k+1], 1'b0, 32'h0, 4'hf, (k == 2) ? CTI_EOB : CTI_INCR, BTE_WRAP4);
            else       beat(w4_adr[3], 1'b0, 32'h0, 4'hf, CTI_CLASSIC, BTE_LINEAR);
        end
        @(negedge clk); chk("w4_after_ack", 32'(bus.ACK), 32'd0);
        tick();
        idle_bus();
        tick();
        tick();

        // window errors, memory untouched
        classic(32'h0FFC, 1'b1, 32'h0000_0BAD, 4'hf, a1, a2, e2, rd);
        chk("oor_lo_ack", 32'(a2), 32'd0);
        chk("oor_lo_err", 32'(e2), 32'd1);
        classic(32'h1040, 1'b1, 32'h0000_0BAD, 4'hf, a1, a2, e2, rd);
        chk("oor_hi_ack", 32'(a2), 32'd0);
        chk("oor_hi_err", 32'(e2), 32'd1);
        classic(32'h1000, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("oor_idx0", rd, 32'd0);
        classic(32'h103C, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("oor_idx15", rd, 32'd15);

        // constant burst: write then read same word
        beat(32'h101C, 1'b1, 32'hCAFEF00D, 4'hf, CTI_CONST, BTE_LINEAR);
        @(negedge clk); chk("raw_lat_ack", 32'(bus.ACK), 32'd0);
        tick();
        @(negedge clk); chk("raw_wr_ack", 32'(bus.ACK), 32'd1);
        tick();
        beat(32'h101C, 1'b0, 32'h0, 4'hf, CTI_EOB, BTE_LINEAR);
        @(negedge clk);
        chk("raw_rd_ack", 32'(bus.ACK), 32'd1);
        chk("raw_rd_dat", bus.DAT_R, 32'hCAFEF00D);
        tick();
        idle_bus();
        tick();

        // linear read burst aborted after two beats
        beat(32'h1000, 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_LINEAR);
        @(negedge clk); chk("ab_lat_ack", 32'(bus.ACK), 32'd0);
        tick();
        @(negedge clk); chk("ab_ack0", 32'(bus.ACK), 32'd1); chk("ab_dat0", bus.DAT_R, 32'd0);
        tick();
        beat(32'h1004, 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_LINEAR);
        @(negedge clk); chk("ab_ack1", 32'(bus.ACK), 32'd1); chk("ab_dat1", bus.DAT_R, 32'd1);
        tick();
        idle_bus();
        @(negedge clk); chk("ab_drop_ack", 32'(bus.ACK), 32'd0);
        tick();
        classic(32'h1014, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("ab_next_c1", 32'(a1), 32'd0);
        chk("ab_next_c2", 32'(a2), 32'd1);
        chk("ab_next_dat", rd, 32'd5);

        // linear burst running off the window end
        beat(32'h1038, 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_LINEAR);
        tick();
        @(negedge clk); chk("end_dat14", bus.DAT_R, 32'd14);
        tick();
        beat(32'h103C, 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_LINEAR);
        @(negedge clk); chk("end_dat15", bus.DAT_R, 32'd15);
        tick();
        beat(32'h1040, 1'b0, 32'h0, 4'hf, CTI_INCR, BTE_LINEAR);
        @(negedge clk);
        chk("end_ack", 32'(bus.ACK), 32'd0);
        chk("end_err", 32'(bus.ERR), 32'd1);
        tick();
        idle_bus();
        tick();

        // reset during beat 3 of an 8-beat write burst
        beat(32'h1000, 1'b1, 32'hA0, 4'hf, CTI_INCR, BTE_LINEAR);
        tick();
        @(negedge clk); chk("rb_ack0", 32'(bus.ACK), 32'd1);
        tick();
        beat(32'h1004, 1'b1, 32'hA1, 4'hf, CTI_INCR, BTE_LINEAR);
        @(negedge clk); chk("rb_ack1", 32'(bus.ACK), 32'd1);
        tick();
        beat(32'h1008, 1'b1, 32'hA2, 4'hf, CTI_INCR, BTE_LINEAR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rb_post_ack", 32'(bus.ACK), 32'd0);
        chk("rb_post_err", 32'(bus.ERR), 32'd0);
        chk("rb_post_datr", bus.DAT_R, 32'h0);
        tick();
        idle_bus();
        tick();
        tick();
        classic(32'h1000, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("rb_idx0", rd, 32'hA0);
        classic(32'h1004, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("rb_idx1", rd, 32'hA1);
        classic(32'h1008, 1'b0, 32'h0, 4'hf, a1, a2, e2, rd);
        chk("rb_idx2", rd, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
